imem_ctrl_arb: RTL and testbench

- Owns the instruction SRAM port and shares it between two requesters: the IF-stage fetch port and the program-loader port.
- Sequences CPU bring-up through IDLE -> LOAD -> RUN and drives the `start` enable consumed by the IF stage.
- Sits between the IF stage, the external loader and the single-port synchronous IMEM. IMEM read latency is 1 cycle.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/imem_rd_tracker.sv | 39 +++
 rtl/imem_ctrl_arb.sv | 137 +++++++++++++
 tb/tb_imem_ctrl_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and defaults for the instruction-memory controller/arbiter.
//   ctrl_state_e : bring-up sequencer states (IDLE=0, LOAD=1, RUN=2)
//   imem_req_t   : one requester's view of the IMEM port (req, we, addr, wdata)
//   DEF_INST_*   : default IMEM geometry (word address / word data widths)
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DEF_INST_ADDR_WIDTH = 10;
    localparam int DEF_INST_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } ctrl_state_e;

    // Field widths follow the package defaults; the top module is intended to
    // be built with its width parameters left at these values.
    typedef struct packed {
        logic                           req;
        logic                           we;
        logic [DEF_INST_ADDR_WIDTH-1:0] addr;
        logic [DEF_INST_DATA_WIDTH-1:0] wdata;
    } imem_req_t;

endpackage

// File: rtl/imem_rd_tracker.sv
// -----------------------------------------------------------------------------
// imem_rd_tracker
// Registers a valid bit and a requester tag for every granted IMEM read and
// steers the 1-cycle-later read return to the fetch or loader port.
//   clk          : system clock
//   rst          : asynchronous active-low reset (drops any in-flight read)
//   i_rd_fire    : a read was granted to IMEM this cycle
//   i_rd_ldr     : that read belongs to the loader (0 = fetch)
//   o_f_rvalid   : one-cycle pulse, fetch read data valid on imem_data
//   o_l_rvalid   : one-cycle pulse, loader read data valid on imem_data
// -----------------------------------------------------------------------------
module imem_rd_tracker (
    input  logic clk,
    input  logic rst,
    input  logic i_rd_fire,
    input  logic i_rd_ldr,
    output logic o_f_rvalid,
    output logic o_l_rvalid
);

    logic r_valid;
    logic r_tag;

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_tag   <= 1'b0;
        end else begin
            r_valid <= i_rd_fire;
            r_tag   <= i_rd_ldr;
        end
    end

    assign o_f_rvalid = r_valid & ~r_tag;
    assign o_l_rvalid = r_valid &  r_tag;

endmodule

// File: rtl/imem_ctrl_arb.sv
// -----------------------------------------------------------------------------
// imem_ctrl_arb
// Owns the single-port synchronous IMEM (1-cycle read latency) and shares it
// between the IF-stage fetch port and the program loader, while sequencing
// CPU bring-up IDLE -> LOAD -> RUN.
//   clk, rst          : clock, asynchronous active-low reset
//   ld_start/ld_done  : loader pulses (IDLE->LOAD, LOAD->RUN)
//   halt_req          : pulse, RUN->IDLE
//   f_*               : fetch request/grant/read-return port
//   l_*               : loader request/grant/read-return port, l_err sticky
//   cpu_start         : IF-stage enable (high in RUN)
//   imem_*            : SRAM port; imem_data is valid 1 cycle after a read
//   load_cnt          : words written during the current LOAD (saturating)
//   ctrl_state        : current sequencer state
// -----------------------------------------------------------------------------
module imem_ctrl_arb
    import cpu_pkg::*;
#(
    parameter int INST_ADDR_WIDTH = DEF_INST_ADDR_WIDTH,
    parameter int INST_DATA_WIDTH = DEF_INST_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_start,
    input  logic                       ld_done,
    input  logic                       halt_req,
    input  logic                       f_req,
    input  logic [INST_ADDR_WIDTH-1:0] f_addr,
    output logic                       f_gnt,
    output logic                       f_rvalid,
    output logic [INST_DATA_WIDTH-1:0] f_rdata,
    input  logic                       l_req,
    input  logic                       l_we,
    input  logic [INST_ADDR_WIDTH-1:0] l_addr,
    input  logic [INST_DATA_WIDTH-1:0] l_wdata,
    output logic                       l_gnt,
    output logic                       l_rvalid,
    output logic [INST_DATA_WIDTH-1:0] l_rdata,
    output logic                       l_err,
    output logic                       cpu_start,
    output logic                       imem_en,
    output logic                       imem_we,
    output logic [INST_ADDR_WIDTH-1:0] imem_addr,
    output logic [INST_DATA_WIDTH-1:0] imem_wdata,
    input  logic [INST_DATA_WIDTH-1:0] imem_data,
    output logic [INST_ADDR_WIDTH:0]   load_cnt,
    output logic [1:0]                 ctrl_state
);

    localparam logic [INST_ADDR_WIDTH:0] LOAD_CNT_MAX = {1'b1, {INST_ADDR_WIDTH{1'b0}}};

    ctrl_state_e              r_state;
    ctrl_state_e              w_state_nxt;
    logic [INST_ADDR_WIDTH:0] r_load_cnt;
    logic                     r_l_err;
    imem_req_t                w_f;
    imem_req_t                w_l;
    imem_req_t                w_win;

    assign w_f = '{req: f_req, we: 1'b0, addr: f_addr, wdata: '0};
    assign w_l = '{req: l_req, we: l_we, addr: l_addr, wdata: l_wdata};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        f_gnt       = 1'b0;
        l_gnt       = 1'b0;
        case (r_state)
            IDLE: begin
                // ld_start wins over a coincident ld_done: only the LOAD
                // transition is possible from here.
                if (ld_start) w_state_nxt = LOAD;
            end
            LOAD: begin
                l_gnt = l_req;
                if (ld_done) w_state_nxt = RUN;
            end
            RUN: begin
                // Fetch has strict priority; loader writes are never granted.
                f_gnt = f_req;
                l_gnt = l_req & ~l_we & ~f_req;
                if (halt_req) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The winner's request drives the SRAM port; req here means "granted".
    always_comb begin
        w_win     = w_l;
        w_win.req = l_gnt;
        if (f_gnt) w_win = w_f;
    end

    assign imem_en    = w_win.req;
    assign imem_we    = w_win.req & w_win.we;
    assign imem_addr  = w_win.addr;
    assign imem_wdata = w_win.wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_load_cnt <= '0;
        end else if (r_state == IDLE && ld_start) begin
            r_load_cnt <= '0;
        end else if (r_state == LOAD && l_gnt && l_we && r_load_cnt != LOAD_CNT_MAX) begin
            r_load_cnt <= r_load_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                    r_l_err <= 1'b0;
        else if (r_state == RUN && l_req && l_we)    r_l_err <= 1'b1;
    end

    imem_rd_tracker u_rd_tracker (
        .clk        (clk),
        .rst        (rst),
        .i_rd_fire  (imem_en & ~imem_we),
        .i_rd_ldr   (l_gnt),
        .o_f_rvalid (f_rvalid),
        .o_l_rvalid (l_rvalid)
    );

    assign f_rdata    = imem_data;
    assign l_rdata    = imem_data;
    assign cpu_start  = (r_state == RUN);
    assign load_cnt   = r_load_cnt;
    assign l_err      = r_l_err;
    assign ctrl_state = r_state;

endmodule

// File: tb/tb_imem_ctrl_arb.sv
// -----------------------------------------------------------------------------
// tb_imem_ctrl_arb
// Self-checking bench for imem_ctrl_arb: directed bring-up/arbitration
// scenarios followed by randomized traffic, all compared every cycle against
// a behavioural model of the bring-up rules and an array image of IMEM.
// -----------------------------------------------------------------------------
module tb_imem_ctrl_arb;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    localparam int S_IDLE = 0;
    localparam int S_LOAD = 1;
    localparam int S_RUN  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_start, ld_done, halt_req;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt, f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          l_req, l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_gnt, l_rvalid, l_err;
    logic [DW-1:0] l_rdata;
    logic          cpu_start, imem_en, imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata, imem_data;
    logic [AW:0]   load_cnt;
    logic [1:0]    ctrl_state;

    always #5 clk = ~clk;

    imem_ctrl_arb #(.INST_ADDR_WIDTH(AW), .INST_DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .ld_start(ld_start), .ld_done(ld_done), .halt_req(halt_req),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
        .cpu_start(cpu_start), .imem_en(imem_en), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_data(imem_data),
        .load_cnt(load_cnt), .ctrl_state(ctrl_state)
    );

    // Synchronous single-port SRAM driven only by the DUT's imem_* port.
    logic [DW-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (imem_en) begin
            if (imem_we) sram[imem_addr] <= imem_wdata;
            else         imem_data       <= sram[imem_addr];
        end
    end

    // Reference model state
    int            m_state;
    int            m_cnt;
    bit            m_err;
    bit            m_pv, m_pl;
    logic [DW-1:0] m_pdata;
    logic [DW-1:0] ref_mem [DEPTH];
    bit            rst_hit;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_cnt   = 0;
        m_err   = 1'b0;
        m_pv    = 1'b0;
        m_pl    = 1'b0;
    endtask

    task automatic idle_inputs();
        ld_start = 0; ld_done = 0; halt_req = 0;
        f_req = 0; f_addr = '0;
        l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
    endtask

    // One clock: check all outputs against the model, then advance the model
    // across the rising edge. Called at a falling edge with inputs driven.
    task automatic cycle();
        bit efg, elg, ewe;
        #1;
        efg = (m_state == S_RUN) && f_req;
        elg = ((m_state == S_LOAD) && l_req) ||
              ((m_state == S_RUN) && l_req && !l_we && !f_req);
        ewe = elg && l_we;
        check("f_gnt", f_gnt, efg);
        check("l_gnt", l_gnt, elg);
        check("imem_en", imem_en, efg || elg);
        check("imem_we", imem_we, ewe);
        if (efg || elg) check("imem_addr", imem_addr, efg ? f_addr : l_addr);
        if (ewe) check("imem_wdata", imem_wdata, l_wdata);
        check("cpu_start", cpu_start, m_state == S_RUN);
        check("ctrl_state", ctrl_state, m_state);
        check("l_err", l_err, m_err);
        check("load_cnt", load_cnt, m_cnt);
        check("f_rvalid", f_rvalid, m_pv && !m_pl);
        check("l_rvalid", l_rvalid, m_pv && m_pl);
        if (m_pv) begin
            check("f_rdata", f_rdata, m_pdata);
            check("l_rdata", l_rdata, m_pdata);
        end
        @(posedge clk);
        if (rst_hit) begin
            rst     = 1'b0;
            rst_hit = 1'b0;
        end
        if (!rst) begin
            model_reset();
        end else begin
            m_pv    = (efg || elg) && !ewe;
            m_pl    = elg;
            m_pdata = ref_mem[efg ? f_addr : l_addr];
            if (ewe) begin
                ref_mem[l_addr] = l_wdata;
                if (m_cnt < DEPTH) m_cnt++;
            end
            if (m_state == S_RUN && l_req && l_we) m_err = 1'b1;
            case (m_state)
                S_IDLE: if (ld_start) begin m_state = S_LOAD; m_cnt = 0; end
                S_LOAD: if (ld_done)  m_state = S_RUN;
                default: if (halt_req) m_state = S_IDLE;
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        rst_hit = 1'b0;
        rst     = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        check("reset_state", ctrl_state, S_IDLE);
        check("reset_cpu_start", cpu_start, 1'b0);
        check("reset_load_cnt", load_cnt, 0);
        rst = 1'b1;

        // Reset mid-read: get to RUN, issue a fetch, reset on its edge.
        ld_start = 1; cycle(); idle_inputs();
        ld_done  = 1; cycle(); idle_inputs();
        f_req = 1; f_addr = 10'd5; rst_hit = 1'b1; cycle(); idle_inputs();
        cycle();
        check("rstmid_f_rvalid", f_rvalid, 1'b0);
        check("rstmid_state", ctrl_state, S_IDLE);
        check("rstmid_cpu_start", cpu_start, 1'b0);
        rst = 1'b1;

        // Boot load of 4 words.
        ld_start = 1; cycle(); idle_inputs();
        for (int i = 0; i < 4; i++) begin
            l_req = 1; l_we = 1; l_addr = AW'(i); l_wdata = DW'(32'hA0 + i);
            cycle();
        end
        idle_inputs();
        check("boot_load_cnt", load_cnt, 4);
        ld_done = 1; cycle(); idle_inputs();
        check("boot_state", ctrl_state, S_RUN);
        check("boot_cpu_start", cpu_start, 1'b1);

        // Fetch read of addr 2.
        f_req = 1; f_addr = 10'd2; cycle(); idle_inputs();
        check("fetch_rvalid", f_rvalid, 1'b1);
        check("fetch_rdata", f_rdata, 32'hA2);
        cycle();

        // Contention: fetch holds off a loader read for 3 cycles.
        for (int i = 0; i < 4; i++) begin
            f_req = (i < 3); f_addr = 10'd1;
            l_req = 1; l_we = 0; l_addr = 10'd0;
            #1;
            check("contend_l_gnt", l_gnt, i == 3);
            cycle();
        end
        idle_inputs();
        check("contend_l_rvalid", l_rvalid, 1'b1);
        check("contend_l_rdata", l_rdata, 32'hA0);

        // Loader write in RUN is refused and flagged.
        l_req = 1; l_we = 1; l_addr = 10'd1; l_wdata = 32'hFF;
        #1;
        check("runwr_l_gnt", l_gnt, 1'b0);
        check("runwr_imem_we", imem_we, 1'b0);
        cycle(); idle_inputs();
        check("runwr_l_err", l_err, 1'b1);
        f_req = 1; f_addr = 10'd1; cycle(); idle_inputs();
        check("runwr_fetch_rdata", f_rdata, 32'hA1);
        check("runwr_l_err_sticky", l_err, 1'b1);

        // Halt with a coincident fetch.
        halt_req = 1; f_req = 1; f_addr = 10'd3;
        #1;
        check("halt_f_gnt", f_gnt, 1'b1);
        cycle(); idle_inputs();
        check("halt_f_rvalid", f_rvalid, 1'b1);
        check("halt_f_rdata", f_rdata, 32'hA3);
        check("halt_state", ctrl_state, S_IDLE);
        check("halt_cpu_start", cpu_start, 1'b0);
        ld_done = 1; cycle(); idle_inputs();
        check("idle_ld_done_ignored", ctrl_state, S_IDLE);

        // ld_start and ld_done together in IDLE: only ld_start acts.
        ld_start = 1; ld_done = 1; cycle(); idle_inputs();
        check("start_done_state", ctrl_state, S_LOAD);

        // Saturation of load_cnt at 2^AW.
        for (int i = 0; i < DEPTH + 6; i++) begin
            l_req = 1; l_we = 1; l_addr = AW'(i); l_wdata = $urandom;
            cycle();
        end
        idle_inputs();
        check("load_cnt_sat", load_cnt, DEPTH);
        ld_done = 1; cycle(); idle_inputs();
        check("sat_hold_in_run", load_cnt, DEPTH);

        // Randomized traffic with occasional pulses and resets.
        for (int n = 0; n < 3000; n++) begin
            if (!rst) rst = 1'b1;
            ld_start = ($urandom_range(0, 15) == 0);
            ld_done  = ($urandom_range(0, 15) == 0);
            halt_req = ($urandom_range(0, 31) == 0);
            f_req    = $urandom_range(0, 1);
            f_addr   = AW'($urandom_range(0, 15));
            l_req    = $urandom_range(0, 1);
            l_we     = $urandom_range(0, 1);
            l_addr   = AW'($urandom_range(0, 15));
            l_wdata  = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                model_reset();
            end
            cycle();
        end
        idle_inputs();
        rst = 1'b1;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
